// File: rtl/mass_state_writeback_if.sv
// rtl/mass_state_writeback_if.sv - pipeline, host and RAM write-port signal bundle for mass_state_writeback
interface mass_state_writeback_if #(
    parameter int SIZE       = 27,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [SIZE-1:0]       in_data;
    logic                  host_valid;
    logic                  host_ready;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [SIZE-1:0]       host_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [SIZE-1:0]       d;

    modport master (
        output in_valid, in_addr, in_data, host_valid, host_addr, host_data,
        input  in_ready, host_ready, we, w_addr, d
    );

    modport slave (
        input  in_valid, in_addr, in_data, host_valid, host_addr, host_data,
        output in_ready, host_ready, we, w_addr, d
    );
endinterface

// File: rtl/mass_state_writeback.sv
// rtl/mass_state_writeback.sv - mass-state RAM write controller; WB_HOST_LOAD_EN enables the host load port
module mass_state_writeback #(
    parameter int SIZE       = 27,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_MASSES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    mass_state_writeback_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  addr_err,
    output logic                  seq_err
);
    localparam logic [ADDR_WIDTH:0] NUM_LIMIT = (ADDR_WIDTH+1)'(NUM_MASSES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  in_acc, host_acc, wr_valid, in_range, count_last;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SIZE-1:0]       wr_data;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [SIZE-1:0]       d_q;

    assign bus.in_ready = (state_q == RUN);
    assign in_acc       = bus.in_valid & bus.in_ready;

`ifdef WB_HOST_LOAD_EN
    assign bus.host_ready = (state_q == IDLE) & ~frame_start;
    assign host_acc       = bus.host_valid & bus.host_ready;
    // Pipeline wins the port; host is only ever accepted in IDLE so the two never collide.
    assign wr_addr        = in_acc ? bus.in_addr : bus.host_addr;
    assign wr_data        = in_acc ? bus.in_data : bus.host_data;
`else
    logic host_unused;
    assign host_unused    = ^{bus.host_valid, bus.host_addr, bus.host_data};
    assign bus.host_ready = 1'b0;
    assign host_acc       = 1'b0;
    assign wr_addr        = bus.in_addr;
    assign wr_data        = bus.in_data;
`endif

    assign wr_valid   = in_acc | host_acc;
    assign in_range   = ({1'b0, wr_addr} < NUM_LIMIT);
    assign count_last = ((wr_count + 1'b1) == NUM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = RUN;
            RUN:     if (in_acc && count_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered write port: an accept at one edge becomes we/w_addr/d for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            w_addr_q <= '0;
            d_q      <= '0;
            wr_count <= '0;
            addr_err <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            we_q <= wr_valid & in_range;
            if (wr_valid && in_range) begin
                w_addr_q <= wr_addr;
                d_q      <= wr_data;
            end
            if (wr_valid && !in_range) begin
                addr_err <= 1'b1;
            end
            // Dropped out-of-range beats still count toward frame completion.
            if (in_acc && wr_count != NUM_LIMIT) begin
                wr_count <= wr_count + 1'b1;
            end
            if (state_q == RUN && frame_start) begin
                seq_err <= 1'b1;
            end
            if (state_q == IDLE && frame_start) begin
                wr_count <= '0;
                addr_err <= 1'b0;
                seq_err  <= 1'b0;
            end
        end
    end

    assign bus.we     = we_q;
    assign bus.w_addr = w_addr_q;
    assign bus.d      = d_q;
    assign busy       = (state_q == RUN);
    assign frame_done = (state_q == DONE);
endmodule

// File: tb/tb_mass_state_writeback.sv
// tb/tb_mass_state_writeback.sv - scoreboard bench for mass_state_writeback (16- and 12-mass instances)
module tb_mass_state_writeback;
`ifdef WB_HOST_LOAD_EN
    localparam logic HOST_EN = 1'b1;
`else
    localparam logic HOST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  addr;
        logic [26:0] data;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start0, frame_start1;
    logic busy0, busy1, frame_done0, frame_done1;
    logic [4:0] wr_count0, wr_count1;
    logic addr_err0, addr_err1, seq_err0, seq_err1;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int passed = 0;
    int done0 = 0;
    int done1 = 0;

    mass_state_writeback_if #(.SIZE(27), .ADDR_WIDTH(4)) if0 ();
    mass_state_writeback_if #(.SIZE(27), .ADDR_WIDTH(4)) if1 ();

    mass_state_writeback #(.SIZE(27), .ADDR_WIDTH(4), .NUM_MASSES(16)) u0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start0), .bus(if0.slave),
        .busy(busy0), .frame_done(frame_done0), .wr_count(wr_count0),
        .addr_err(addr_err0), .seq_err(seq_err0)
    );

    mass_state_writeback #(.SIZE(27), .ADDR_WIDTH(4), .NUM_MASSES(12)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start1), .bus(if1.slave),
        .busy(busy1), .frame_done(frame_done1), .wr_count(wr_count1),
        .addr_err(addr_err1), .seq_err(seq_err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.we) begin
                if (q0.size() == 0) begin
                    checks++;
                    $display("FAIL u0_unexpected_write: got addr %0h data %0h expected no write", if0.w_addr, if0.d);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("u0_w_addr", 32'(if0.w_addr), 32'(e.addr));
                    check("u0_d", 32'(if0.d), 32'(e.data));
                    check("u0_frame_done", 32'(frame_done0), 32'(e.done));
                end
            end else if (frame_done0) begin
                checks++;
                $display("FAIL u0_done_without_write: got frame_done 1 expected final write");
            end
            if (frame_done0) done0++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (if1.we) begin
                if (q1.size() == 0) begin
                    checks++;
                    $display("FAIL u1_unexpected_write: got addr %0h data %0h expected no write", if1.w_addr, if1.d);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("u1_w_addr", 32'(if1.w_addr), 32'(e.addr));
                    check("u1_d", 32'(if1.d), 32'(e.data));
                    check("u1_frame_done", 32'(frame_done1), 32'(e.done));
                end
            end
            if (frame_done1) done1++;
        end
    end

    task automatic beat0(input logic [3:0] a, input logic [26:0] dat, input logic dn);
        if0.in_valid = 1'b1;
        if0.in_addr  = a;
        if0.in_data  = dat;
        q0.push_back('{addr: a, data: dat, done: dn});
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
    endtask

    task automatic beat1(input logic [3:0] a, input logic [26:0] dat, input logic dn, input logic push);
        if1.in_valid = 1'b1;
        if1.in_addr  = a;
        if1.in_data  = dat;
        if (push) q1.push_back('{addr: a, data: dat, done: dn});
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
    endtask

    task automatic start0();
        frame_start0 = 1'b1;
        @(posedge clk); #1;
        frame_start0 = 1'b0;
    endtask

    task automatic start1();
        frame_start1 = 1'b1;
        @(posedge clk); #1;
        frame_start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [3:0] u1_addrs [12];
        u1_addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        rst_n = 1'b0;
        frame_start0 = 1'b0; frame_start1 = 1'b0;
        if0.in_valid = 1'b0; if0.in_addr = '0; if0.in_data = '0;
        if0.host_valid = 1'b0; if0.host_addr = '0; if0.host_data = '0;
        if1.in_valid = 1'b0; if1.in_addr = '0; if1.in_data = '0;
        if1.host_valid = 1'b0; if1.host_addr = '0; if1.host_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(if0.we), 32'd0);
        check("rst_w_addr", 32'(if0.w_addr), 32'd0);
        check("rst_d", 32'(if0.d), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_frame_done", 32'(frame_done0), 32'd0);
        check("rst_wr_count", 32'(wr_count0), 32'd0);
        check("rst_errs", 32'({addr_err0, seq_err0}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_host_ready", 32'(if0.host_ready), 32'(HOST_EN));

        // Reset in the middle of a frame
        start0();
        for (int i = 0; i < 5; i++) beat0(4'(i), 27'(i + 100), 1'b0);
        check("t1_wr_count_before", 32'(wr_count0), 32'd5);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t1_we", 32'(if0.we), 32'd0);
        check("t1_wr_count", 32'(wr_count0), 32'd0);
        check("t1_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full back-to-back frame
        start0();
        check("t2_busy", 32'(busy0), 32'd1);
        check("t2_in_ready", 32'(if0.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) beat0(4'(i), 27'(i * 3), i == 15);
        check("t2_frame_done", 32'(frame_done0), 32'd1);
        check("t2_busy_done", 32'(busy0), 32'd0);
        check("t2_wr_count", 32'(wr_count0), 32'd16);
        @(posedge clk); #1;
        check("t2_done_pulse", 32'(frame_done0), 32'd0);

        // Host write in IDLE
        if0.host_valid = 1'b1; if0.host_addr = 4'd7; if0.host_data = 27'h7FFFFFF;
        if (HOST_EN) q0.push_back('{addr: 4'd7, data: 27'h7FFFFFF, done: 1'b0});
        #1;
        check("t3_host_ready", 32'(if0.host_ready), 32'(HOST_EN));
        @(posedge clk); #1;
        if0.host_valid = 1'b0;
        @(posedge clk); #1;

        // frame_start mid-RUN, duplicate addresses
        start0();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) frame_start0 = 1'b1;
            beat0(4'(i % 8), 27'(i * 1000 + 7), i == 15);
            frame_start0 = 1'b0;
            if (i == 8) begin
                check("t5_seq_err", 32'(seq_err0), 32'd1);
                check("t5_wr_count", 32'(wr_count0), 32'd9);
            end
        end
        check("t5_frame_done", 32'(frame_done0), 32'd1);
        @(posedge clk); #1;

        // Gapped input, host held, frame_start with in_valid in IDLE
        if0.host_valid = 1'b1; if0.host_addr = 4'd2; if0.host_data = 27'd1;
        frame_start0 = 1'b1;
        if0.in_valid = 1'b1; if0.in_addr = 4'd3; if0.in_data = 27'd3;
        #1;
        check("t6_host_ready_fs", 32'(if0.host_ready), 32'd0);
        check("t6_in_ready_idle", 32'(if0.in_ready), 32'd0);
        @(posedge clk); #1;
        frame_start0 = 1'b0;
        if0.in_valid = 1'b0;
        check("t6_seq_err_clr", 32'(seq_err0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            beat0(4'(i), 27'h4000000 | 27'(i), i == 15);
            if (i < 15) begin
                check("t6_busy_gap", 32'(busy0), 32'd1);
                check("t6_host_ready_run", 32'(if0.host_ready), 32'd0);
                @(posedge clk); #1;
            end
        end
        if0.host_valid = 1'b0;
        check("t6_frame_done", 32'(frame_done0), 32'd1);
        check("t6_wr_count", 32'(wr_count0), 32'd16);
        @(posedge clk); #1;

        // Range error on the 12-mass instance
        start1();
        for (int i = 0; i < 12; i++) begin
            beat1(u1_addrs[i], 27'(i + 500), i == 11, u1_addrs[i] != 4'd13);
            if (i == 5) begin
                check("t4_addr_err", 32'(addr_err1), 32'd1);
                check("t4_wr_count", 32'(wr_count1), 32'd6);
            end
        end
        check("t4_frame_done", 32'(frame_done1), 32'd1);
        check("t4_wr_count_full", 32'(wr_count1), 32'd12);
        @(posedge clk); #1;
        start1();
        check("t4_addr_err_clr", 32'(addr_err1), 32'd0);
        check("t4_wr_count_clr", 32'(wr_count1), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("u0_done_pulses", 32'(done0), 32'd3);
        check("u1_done_pulses", 32'(done1), 32'd1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
